// File: rtl/vc_fifo.sv
// Multi-channel synchronous FIFO: VCS independent virtual-channel queues sharing one
// write port and one read port, with per-VC flags, occupancy and sticky overflow.
module vc_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned VCS       = 2,
  parameter int unsigned AF_MARGIN = 1,
  parameter int unsigned OUT_REG   = 0,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1,
  localparam int unsigned VW = (VCS > 1) ? $clog2(VCS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    din,
  input  logic                wr_en,
  input  logic [VW-1:0]       wr_vc,
  input  logic                rd_en,
  input  logic [VW-1:0]       rd_vc,
  output logic [WIDTH-1:0]    dout,
  output logic                dout_valid,
  output logic [VCS-1:0]      empty,
  output logic [VCS-1:0]      full,
  output logic [VCS-1:0]      nearly_empty,
  output logic [VCS-1:0]      almost_full,
  output logic [VCS*CW-1:0]   count,
  output logic [VCS-1:0]      overflow
);

  localparam int unsigned MW = $clog2(VCS * DEPTH);
  localparam logic [CW-1:0] AfLevel = CW'(DEPTH - AF_MARGIN);

  logic [CW-1:0]    wr_ptr_q [VCS];
  logic [CW-1:0]    rd_ptr_q [VCS];
  logic [WIDTH-1:0] mem_q    [VCS*DEPTH];
  logic [VCS-1:0]   overflow_q;

  logic [VCS-1:0]   rd_sel;
  logic [VCS-1:0]   wr_acc;
  logic [VCS-1:0]   rd_acc;
  logic [VCS-1:0]   ovf_set;
  logic [WIDTH-1:0] head;

  // An out-of-range VC index matches no channel, so it is never accepted and never flags overflow.
  always_comb begin
    empty        = '0;
    full         = '0;
    nearly_empty = '0;
    almost_full  = '0;
    count        = '0;
    rd_sel       = '0;
    wr_acc       = '0;
    rd_acc       = '0;
    ovf_set      = '0;
    head         = '0;
    for (int v = 0; v < VCS; v++) begin
      count[v*CW +: CW] = wr_ptr_q[v] - rd_ptr_q[v];
      empty[v]          = (wr_ptr_q[v] == rd_ptr_q[v]);
      full[v]           = (wr_ptr_q[v][AW-1:0] == rd_ptr_q[v][AW-1:0]) &&
                          (wr_ptr_q[v][AW] != rd_ptr_q[v][AW]);
      nearly_empty[v]   = ((wr_ptr_q[v] - rd_ptr_q[v]) == CW'(1));
      almost_full[v]    = ((wr_ptr_q[v] - rd_ptr_q[v]) >= AfLevel);
      rd_sel[v]         = (rd_vc == VW'(v));
      wr_acc[v]         = wr_en && (wr_vc == VW'(v)) && !full[v];
      ovf_set[v]        = wr_en && (wr_vc == VW'(v)) && full[v];
      rd_acc[v]         = rd_en && rd_sel[v] && !empty[v];
      if (rd_sel[v]) begin
        head = mem_q[MW'(v * DEPTH) + MW'(rd_ptr_q[v][AW-1:0])];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < VCS; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
      end
      overflow_q <= '0;
    end else begin
      for (int v = 0; v < VCS; v++) begin
        if (wr_acc[v]) wr_ptr_q[v] <= wr_ptr_q[v] + CW'(1);
        if (rd_acc[v]) rd_ptr_q[v] <= rd_ptr_q[v] + CW'(1);
      end
      overflow_q <= overflow_q | ovf_set;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VCS; v++) begin
      if (wr_acc[v]) begin
        mem_q[MW'(v * DEPTH) + MW'(wr_ptr_q[v][AW-1:0])] <= din;
      end
    end
  end

  assign overflow = overflow_q;

  if (OUT_REG != 0) begin : g_reg
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else begin
        dout_valid_q <= |rd_acc;
        if (|rd_acc) dout_q <= head;
      end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
  end else begin : g_fwft
    assign dout       = head;
    assign dout_valid = |(rd_sel & ~empty);
  end

endmodule

// File: tb/tb_vc_fifo.sv
// Directed bench for vc_fifo: one FWFT instance and one registered-output instance share stimulus.
module tb_vc_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = '0;
  logic       wr_en = 1'b0;
  logic       wr_vc = 1'b0;
  logic       rd_en = 1'b0;
  logic       rd_vc = 1'b0;

  logic [7:0] dout0, dout1;
  logic       dv0, dv1;
  logic [1:0] empty0, full0, ne0, af0, ovf0;
  logic [1:0] empty1, full1, ne1, af1, ovf1;
  logic [5:0] count0, count1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  vc_fifo #(.WIDTH(8), .DEPTH(4), .VCS(2), .AF_MARGIN(1), .OUT_REG(0)) dut0 (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .wr_vc(wr_vc), .rd_en(rd_en),
    .rd_vc(rd_vc), .dout(dout0), .dout_valid(dv0), .empty(empty0), .full(full0),
    .nearly_empty(ne0), .almost_full(af0), .count(count0), .overflow(ovf0)
  );

  vc_fifo #(.WIDTH(8), .DEPTH(4), .VCS(2), .AF_MARGIN(1), .OUT_REG(1)) dut1 (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .wr_vc(wr_vc), .rd_en(rd_en),
    .rd_vc(rd_vc), .dout(dout1), .dout_valid(dv1), .empty(empty1), .full(full1),
    .nearly_empty(ne1), .almost_full(af1), .count(count1), .overflow(ovf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (empty0 !== 2'b11 || full0 !== 2'b00 || count0 !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_ptrs: empty=%b full=%b count=%h, want 11 00 00", empty0, full0, count0);
    end
    n_checks++;
    if (ne0 !== 2'b00 || af0 !== 2'b00 || ovf0 !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: ne=%b af=%b ovf=%b, want 00 00 00", ne0, af0, ovf0);
    end
    n_checks++;
    if (dout1 !== 8'h00 || dv1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dout: dout=%h dv=%b, want 00 0", dout1, dv1);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_vc = 1'b0; din = 8'hA1 + 8'(i);
      tick();
      n_checks++;
      if (count0[2:0] !== 3'(i + 1) || af0[0] !== (i + 1 >= 3) || full0[0] !== (i == 3) ||
          empty0[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_%0d: count=%0d af=%b full=%b empty1=%b, want %0d %b %b 1",
                 i, count0[2:0], af0[0], full0[0], empty0[1], i + 1, (i + 1 >= 3), (i == 3));
      end
    end
    din = 8'hA5;
    tick();
    idle();
    rd_vc = 1'b0;
    #1;
    n_checks++;
    if (count0[2:0] !== 3'd4 || ovf0 !== 2'b01 || full0[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: count=%0d ovf=%b full=%b, want 4 01 1", count0[2:0], ovf0, full0[0]);
    end
    n_checks++;
    if (dout0 !== 8'hA1) begin
      n_fail++;
      $display("FAIL fwft_head: dout=%h, want a1", dout0);
    end
  endtask

  task automatic test_fwft_pop();
    rd_en = 1'b1; rd_vc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (dout0 !== 8'hA1 + 8'(i) || dv0 !== 1'b1 || (i == 3 && ne0[0] !== 1'b1)) begin
        n_fail++;
        $display("FAIL fwft_pop_%0d: dout=%h dv=%b ne=%b, want %h 1", i, dout0, dv0, ne0[0],
                 8'hA1 + 8'(i));
      end
      tick();
      n_checks++;
      if (dout1 !== 8'hA1 + 8'(i) || dv1 !== 1'b1) begin
        n_fail++;
        $display("FAIL reg_pop_%0d: dout=%h dv=%b, want %h 1", i, dout1, dv1, 8'hA1 + 8'(i));
      end
    end
    idle();
    #1;
    n_checks++;
    if (empty0[0] !== 1'b1 || dv0 !== 1'b0) begin
      n_fail++;
      $display("FAIL drained: empty=%b dv=%b, want 1 0", empty0[0], dv0);
    end
    tick();
    n_checks++;
    if (dv1 !== 1'b0 || dout1 !== 8'hA4) begin
      n_fail++;
      $display("FAIL reg_idle: dv=%b dout=%h, want 0 a4", dv1, dout1);
    end
  endtask

  task automatic test_interleave();
    logic [7:0] exp;
    logic       has;
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'b1; wr_vc = 1'b0; din = 8'h01 + 8'(i);
      tick();
      q0.push_back(8'h01 + 8'(i));
    end
    // VC1 receives its first write while VC0 pops, then the roles alternate.
    for (int i = 0; i < 12; i++) begin
      wr_en = 1'b1; wr_vc = (i % 2 == 0) ? 1'b1 : 1'b0; din = 8'h10 + 8'(i);
      rd_en = 1'b1; rd_vc = ~wr_vc;
      has = rd_vc ? (q1.size() != 0) : (q0.size() != 0);
      exp = has ? (rd_vc ? q1[0] : q0[0]) : 8'h00;
      #1;
      n_checks++;
      if (dv0 !== has || (has && dout0 !== exp)) begin
        n_fail++;
        $display("FAIL interleave_rd_%0d: dout=%h dv=%b, want %h %b", i, dout0, dv0, exp, has);
      end
      tick();
      if (has) begin
        if (rd_vc) void'(q1.pop_front());
        else void'(q0.pop_front());
      end
      if (wr_vc) q1.push_back(8'h10 + 8'(i));
      else q0.push_back(8'h10 + 8'(i));
      n_checks++;
      if (count0[2:0] !== 3'(q0.size()) || count0[5:3] !== 3'(q1.size()) ||
          empty0 !== {q1.size() == 0, q0.size() == 0} || full0 !== 2'b00) begin
        n_fail++;
        $display("FAIL interleave_cnt_%0d: count=%h empty=%b full=%b, want %0d %0d", i, count0,
                 empty0, full0, q0.size(), q1.size());
      end
    end
    wr_en = 1'b0;
    while (q0.size() != 0 || q1.size() != 0) begin
      rd_en = 1'b1; rd_vc = (q0.size() != 0) ? 1'b0 : 1'b1;
      exp = rd_vc ? q1[0] : q0[0];
      #1;
      n_checks++;
      if (dout0 !== exp) begin
        n_fail++;
        $display("FAIL drain: vc=%0d dout=%h, want %h", rd_vc, dout0, exp);
      end
      tick();
      if (rd_vc) void'(q1.pop_front());
      else void'(q0.pop_front());
    end
    idle();
    tick();
  endtask

  task automatic test_same_vc_empty();
    wr_en = 1'b1; rd_en = 1'b1; wr_vc = 1'b1; rd_vc = 1'b1; din = 8'h55;
    #1;
    n_checks++;
    if (dv0 !== 1'b0) begin
      n_fail++;
      $display("FAIL same_empty_pre: dv=%b, want 0", dv0);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (count0[5:3] !== 3'd1 || dv1 !== 1'b0 || dout0 !== 8'h55) begin
      n_fail++;
      $display("FAIL same_empty: count1=%0d dv=%b dout=%h, want 1 0 55", count0[5:3], dv1, dout0);
    end
  endtask

  task automatic test_same_vc_full();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_vc = 1'b1; din = 8'h61 + 8'(i);
      tick();
    end
    idle();
    #1;
    n_checks++;
    if (full0[1] !== 1'b1 || count0[5:3] !== 3'd4) begin
      n_fail++;
      $display("FAIL same_full_pre: full=%b count1=%0d, want 1 4", full0[1], count0[5:3]);
    end
    wr_en = 1'b1; rd_en = 1'b1; wr_vc = 1'b1; rd_vc = 1'b1; din = 8'h99;
    tick();
    idle();
    n_checks++;
    if (count0[5:3] !== 3'd3 || ovf0 !== 2'b11 || dout1 !== 8'h55 || dv1 !== 1'b1) begin
      n_fail++;
      $display("FAIL same_full: count1=%0d ovf=%b dout=%h dv=%b, want 3 11 55 1", count0[5:3],
               ovf0, dout1, dv1);
    end
    #1;
    n_checks++;
    if (dout0 !== 8'h61) begin
      n_fail++;
      $display("FAIL same_full_head: dout=%h, want 61", dout0);
    end
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; wr_vc = 1'b0; din = 8'h33;
    tick();
    din = 8'h44;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_vc = 1'b0;
    tick();
    n_checks++;
    if (dout1 !== 8'h33 || dv1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: dout=%h dv=%b, want 33 1", dout1, dv1);
    end
    tick();
    n_checks++;
    if (dout1 !== 8'h44 || dv1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: dout=%h dv=%b, want 44 1", dout1, dv1);
    end
    idle();
    tick();
    n_checks++;
    if (dout1 !== 8'h44 || dv1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: dout=%h dv=%b, want 44 0", dout1, dv1);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_vc = 1'b0; din = 8'h70 + 8'(i);
      rd_en = (i == 2); rd_vc = 1'b1;
      tick();
    end
    idle();
    n_checks++;
    if (count0[2:0] !== 3'd3 || ovf0[1] !== 1'b1 || dv1 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: count0=%0d ovf1=%b dv=%b, want 3 1 1", count0[2:0], ovf0[1], dv1);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (empty0 !== 2'b11 || count0 !== 6'd0 || ovf0 !== 2'b00 || full0 !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset: empty=%b count=%h ovf=%b full=%b, want 11 00 00 00", empty0,
               count0, ovf0, full0);
    end
    n_checks++;
    if (dv1 !== 1'b0 || dout1 !== 8'h00 || count1 !== 6'd0) begin
      n_fail++;
      $display("FAIL mid_reset_reg: dv=%b dout=%h count=%h, want 0 00 00", dv1, dout1, count1);
    end
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b1; wr_vc = 1'b0; din = 8'h77;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if (count0[2:0] !== 3'd1 || empty0 !== 2'b10) begin
      n_fail++;
      $display("FAIL cold_write: count0=%0d empty=%b, want 1 10", count0[2:0], empty0);
    end
    rd_en = 1'b1; rd_vc = 1'b0;
    #1;
    n_checks++;
    if (dout0 !== 8'h77) begin
      n_fail++;
      $display("FAIL cold_fwft: dout=%h, want 77", dout0);
    end
    tick();
    idle();
    n_checks++;
    if (dout1 !== 8'h77 || dv1 !== 1'b1 || count0[2:0] !== 3'd0) begin
      n_fail++;
      $display("FAIL cold_read: dout=%h dv=%b count0=%0d, want 77 1 0", dout1, dv1, count0[2:0]);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_fwft_pop();
    test_interleave();
    test_same_vc_empty();
    test_same_vc_full();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1);
  end

endmodule
